// File: rtl/sudoku_cursor_ctrl.sv
// -----------------------------------------------------------------------------
// sudoku_cursor_ctrl
//
// Purpose:
//   Moves a cursor over a DIM x DIM Sudoku grid in response to debounced
//   button pulses and performs "increment cell" edits on a synchronous grid
//   RAM. An edit reads the cell under the cursor, refuses it if the cell is a
//   given (or the puzzle is locked), and otherwise writes back value+1,
//   wrapping DIM back to empty (0).
//
// Ports:
//   clk          system clock, all logic on its rising edge
//   rst          synchronous, active-high reset
//   btn_up/down/left/right/center
//                one-cycle press pulses (center = edit)
//   game_lock    high = edits forbidden, cursor moves still allowed
//   rd_addr      grid RAM read address, row*DIM+col of the cursor (comb.)
//   rd_data      cell value returned one clk after rd_addr (0 = empty)
//   rd_fixed     cell is a given, returned alongside rd_data
//   wr_en        one-cycle write strobe
//   wr_addr      write address (holds when wr_en=0)
//   wr_data      write value   (holds when wr_en=0)
//   cur_row      cursor row 0..DIM-1
//   cur_col      cursor column 0..DIM-1
//   busy         high while an edit is in flight (RD_WAIT, WRITE)
//   edit_reject  one-cycle pulse when an edit is refused
// -----------------------------------------------------------------------------
module sudoku_cursor_ctrl #(
  parameter int DIM = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_center,
  input  logic       game_lock,
  output logic [6:0] rd_addr,
  input  logic [3:0] rd_data,
  input  logic       rd_fixed,
  output logic       wr_en,
  output logic [6:0] wr_addr,
  output logic [3:0] wr_data,
  output logic [3:0] cur_row,
  output logic [3:0] cur_col,
  output logic       busy,
  output logic       edit_reject
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WRITE   = 2'd2
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(DIM - 1);
  localparam logic [3:0] MAX_VAL  = 4'(DIM);
  localparam logic [6:0] DIM_W    = 7'(DIM);

  state_t     r_state;
  logic [3:0] r_cur_row;
  logic [3:0] r_cur_col;
  logic [6:0] r_cap_addr;
  logic       r_wr_en;
  logic [6:0] r_wr_addr;
  logic [3:0] r_wr_data;
  logic       r_busy;
  logic       r_edit_reject;

  logic [6:0] w_rd_addr;
  logic [3:0] w_row_dec;
  logic [3:0] w_row_inc;
  logic [3:0] w_col_dec;
  logic [3:0] w_col_inc;
  logic [3:0] w_next_val;

  // Read address follows the cursor directly so the RAM already has the
  // cell under the cursor in flight when the center press is sampled.
  assign w_rd_addr = 7'(r_cur_row) * DIM_W + 7'(r_cur_col);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_row_dec  = r_cur_row - 4'd1;
    w_row_inc  = r_cur_row + 4'd1;
    w_col_dec  = r_cur_col - 4'd1;
    w_col_inc  = r_cur_col + 4'd1;
    w_next_val = 4'd0;

    if (r_cur_row == 4'd0)     w_row_dec = LAST_IDX;
    if (r_cur_row == LAST_IDX) w_row_inc = 4'd0;
    if (r_cur_col == 4'd0)     w_col_dec = LAST_IDX;
    if (r_cur_col == LAST_IDX) w_col_inc = 4'd0;

    // DIM wraps to empty; out-of-range stored values are also cleared.
    if (rd_data < MAX_VAL) w_next_val = rd_data + 4'd1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cur_row     <= 4'd0;
      r_cur_col     <= 4'd0;
      r_cap_addr    <= 7'd0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= 7'd0;
      r_wr_data     <= 4'd0;
      r_busy        <= 1'b0;
      r_edit_reject <= 1'b0;
    end else begin
      // Strobes default low; only the branches below raise them for a cycle.
      r_wr_en       <= 1'b0;
      r_edit_reject <= 1'b0;

      case (r_state)
        IDLE: begin
          // Single press per cycle; the if/else chain is the priority order.
          if (btn_center) begin
            if (game_lock) begin
              r_edit_reject <= 1'b1;
            end else begin
              r_cap_addr <= w_rd_addr;
              r_state    <= RD_WAIT;
              r_busy     <= 1'b1;
            end
          end else if (btn_up) begin
            r_cur_row <= w_row_dec;
          end else if (btn_down) begin
            r_cur_row <= w_row_inc;
          end else if (btn_left) begin
            r_cur_col <= w_col_dec;
          end else if (btn_right) begin
            r_cur_col <= w_col_inc;
          end
        end

        RD_WAIT: begin
          // RAM data for the captured address is valid in this cycle. The
          // lock is not re-checked: an accepted edit always completes.
          if (rd_fixed) begin
            r_edit_reject <= 1'b1;
            r_state       <= IDLE;
            r_busy        <= 1'b0;
          end else begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_cap_addr;
            r_wr_data <= w_next_val;
            r_state   <= WRITE;
          end
        end

        WRITE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_addr     = w_rd_addr;
  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign cur_row     = r_cur_row;
  assign cur_col     = r_cur_col;
  assign busy        = r_busy;
  assign edit_reject = r_edit_reject;

endmodule

// File: tb/tb_sudoku_cursor_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sudoku_cursor_ctrl
//
// Directed bench for sudoku_cursor_ctrl: a table of single-cycle button
// presses with hand-computed cursor positions, followed by hand-written
// edit sequences against a small synchronous RAM model. A second instance
// built with DIM=4 covers the small-grid wrap.
// -----------------------------------------------------------------------------
module tb_sudoku_cursor_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_up, btn_down, btn_left, btn_right, btn_center;
  logic       game_lock;
  logic [6:0] rd_addr;
  logic [3:0] rd_data;
  logic       rd_fixed;
  logic       wr_en;
  logic [6:0] wr_addr;
  logic [3:0] wr_data;
  logic [3:0] cur_row, cur_col;
  logic       busy;
  logic       edit_reject;

  // DIM=4 instance signals
  logic       b4_down;
  logic [6:0] d4_rd_addr;
  logic       d4_wr_en;
  logic [6:0] d4_wr_addr;
  logic [3:0] d4_wr_data;
  logic [3:0] d4_row, d4_col;
  logic       d4_busy, d4_reject;

  // Grid RAM model: registered read, contents set by the stimulus only.
  logic [3:0] mem_val [128];
  logic       mem_fix [128];

  int n_checks = 0;
  int n_fail   = 0;

  sudoku_cursor_ctrl #(.DIM(9)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_center  (btn_center),
    .game_lock   (game_lock),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_fixed    (rd_fixed),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .cur_row     (cur_row),
    .cur_col     (cur_col),
    .busy        (busy),
    .edit_reject (edit_reject)
  );

  sudoku_cursor_ctrl #(.DIM(4)) u_dut4 (
    .clk         (clk),
    .rst         (rst),
    .btn_up      (1'b0),
    .btn_down    (b4_down),
    .btn_left    (1'b0),
    .btn_right   (1'b0),
    .btn_center  (1'b0),
    .game_lock   (1'b0),
    .rd_addr     (d4_rd_addr),
    .rd_data     (4'd0),
    .rd_fixed    (1'b0),
    .wr_en       (d4_wr_en),
    .wr_addr     (d4_wr_addr),
    .wr_data     (d4_wr_data),
    .cur_row     (d4_row),
    .cur_col     (d4_col),
    .busy        (d4_busy),
    .edit_reject (d4_reject)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    rd_data  <= mem_val[rd_addr];
    rd_fixed <= mem_fix[rd_addr];
  end

  typedef struct {
    logic [4:0] btn;      // {center, up, down, left, right}
    int         exp_row;
    int         exp_col;
    int         exp_addr;
  } move_vec_t;

  move_vec_t vecs [14];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_btns(input logic [4:0] b);
    btn_center = b[4];
    btn_up     = b[3];
    btn_down   = b[2];
    btn_left   = b[1];
    btn_right  = b[0];
  endtask

  // Advance one clock; outputs are sampled on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  int        wrap_in  [4];
  int        wrap_exp [4];

  initial begin
    rst       = 1'b1;
    game_lock = 1'b0;
    b4_down   = 1'b0;
    set_btns(5'b00000);
    for (int i = 0; i < 128; i++) begin
      mem_val[i] = 4'd0;
      mem_fix[i] = 1'b0;
    end

    // Walk from (0,0) through every wrap edge and the press priority order.
    vecs[0]  = '{5'b00000, 0, 0,  0};
    vecs[1]  = '{5'b01000, 8, 0, 72};  // up wraps 0 -> 8
    vecs[2]  = '{5'b00010, 8, 8, 80};  // left wraps 0 -> 8
    vecs[3]  = '{5'b00100, 0, 8,  8};  // down wraps 8 -> 0
    vecs[4]  = '{5'b00001, 0, 0,  0};  // right wraps 8 -> 0
    vecs[5]  = '{5'b00100, 1, 0,  9};
    vecs[6]  = '{5'b00110, 2, 0, 18};  // down beats left
    vecs[7]  = '{5'b00011, 2, 8, 26};  // left beats right
    vecs[8]  = '{5'b00001, 2, 0, 18};
    vecs[9]  = '{5'b00001, 2, 1, 19};
    vecs[10] = '{5'b01001, 1, 1, 10};  // up beats right
    vecs[11] = '{5'b00100, 2, 1, 19};
    vecs[12] = '{5'b00001, 2, 2, 20};
    vecs[13] = '{5'b00001, 2, 3, 21};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset cur_row", int'(cur_row), 0);
    check("reset cur_col", int'(cur_col), 0);
    check("reset rd_addr", int'(rd_addr), 0);
    check("reset busy", int'(busy), 0);
    check("reset wr_en", int'(wr_en), 0);
    check("reset wr_addr", int'(wr_addr), 0);
    check("reset wr_data", int'(wr_data), 0);
    check("reset edit_reject", int'(edit_reject), 0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      set_btns(vecs[i].btn);
      step();
      set_btns(5'b00000);
      check($sformatf("vec%0d cur_row", i), int'(cur_row), vecs[i].exp_row);
      check($sformatf("vec%0d cur_col", i), int'(cur_col), vecs[i].exp_col);
      check($sformatf("vec%0d rd_addr", i), int'(rd_addr), vecs[i].exp_addr);
      check($sformatf("vec%0d busy", i), int'(busy), 0);
      check($sformatf("vec%0d wr_en", i), int'(wr_en), 0);
    end

    // Edit at (2,3): cell 21 = 5, center+right together, down held while busy.
    mem_val[21] = 4'd5;
    set_btns(5'b10001);
    step();
    set_btns(5'b00100);
    check("edit c1 busy", int'(busy), 1);
    check("edit c1 wr_en", int'(wr_en), 0);
    check("edit c1 cur_col", int'(cur_col), 3);
    step();
    check("edit c2 busy", int'(busy), 1);
    check("edit c2 wr_en", int'(wr_en), 1);
    check("edit c2 wr_addr", int'(wr_addr), 21);
    check("edit c2 wr_data", int'(wr_data), 6);
    set_btns(5'b00000);
    step();
    check("edit c3 busy", int'(busy), 0);
    check("edit c3 wr_en", int'(wr_en), 0);
    check("edit c3 wr_data hold", int'(wr_data), 6);
    check("edit c3 wr_addr hold", int'(wr_addr), 21);
    check("edit down ignored row", int'(cur_row), 2);
    check("edit right ignored col", int'(cur_col), 3);
    check("edit no reject", int'(edit_reject), 0);

    // Value increment boundaries: 0->1, 8->9, 9->0 (wrap), 12->0 (out of range).
    wrap_in  = '{0, 8, 9, 12};
    wrap_exp = '{1, 9, 0, 0};
    for (int i = 0; i < 4; i++) begin
      mem_val[21] = 4'(wrap_in[i]);
      set_btns(5'b10000);
      step();
      set_btns(5'b00000);
      step();
      check($sformatf("incr %0d wr_en", wrap_in[i]), int'(wr_en), 1);
      check($sformatf("incr %0d wr_data", wrap_in[i]), int'(wr_data), wrap_exp[i]);
      step();
    end

    // Fixed cell: reject after the read, no write.
    mem_val[21] = 4'd3;
    mem_fix[21] = 1'b1;
    set_btns(5'b10000);
    step();
    set_btns(5'b00000);
    check("fixed c1 busy", int'(busy), 1);
    check("fixed c1 reject", int'(edit_reject), 0);
    step();
    check("fixed c2 reject", int'(edit_reject), 1);
    check("fixed c2 wr_en", int'(wr_en), 0);
    check("fixed c2 busy", int'(busy), 0);
    step();
    check("fixed c3 reject", int'(edit_reject), 0);
    check("fixed c3 wr_en", int'(wr_en), 0);
    mem_fix[21] = 1'b0;

    // Locked puzzle: reject next cycle, never busy, no write.
    game_lock = 1'b1;
    set_btns(5'b10000);
    step();
    set_btns(5'b00000);
    check("lock c1 reject", int'(edit_reject), 1);
    check("lock c1 busy", int'(busy), 0);
    check("lock c1 wr_en", int'(wr_en), 0);
    step();
    check("lock c2 reject", int'(edit_reject), 0);
    check("lock c2 wr_en", int'(wr_en), 0);
    check("lock c2 busy", int'(busy), 0);
    // Moves still allowed while locked.
    set_btns(5'b00001);
    step();
    set_btns(5'b00000);
    check("lock move col", int'(cur_col), 4);
    set_btns(5'b00010);
    step();
    set_btns(5'b00000);
    game_lock = 1'b0;

    // Lock raised after the edit was accepted does not cancel it.
    mem_val[21] = 4'd2;
    set_btns(5'b10000);
    step();
    set_btns(5'b00000);
    game_lock = 1'b1;
    step();
    check("late lock wr_en", int'(wr_en), 1);
    check("late lock wr_data", int'(wr_data), 3);
    check("late lock reject", int'(edit_reject), 0);
    step();
    game_lock = 1'b0;

    // Reset during RD_WAIT aborts the edit.
    set_btns(5'b10000);
    step();
    set_btns(5'b00000);
    check("abort pre busy", int'(busy), 1);
    rst = 1'b1;
    step();
    check("abort wr_en", int'(wr_en), 0);
    check("abort busy", int'(busy), 0);
    check("abort cur_row", int'(cur_row), 0);
    check("abort cur_col", int'(cur_col), 0);
    check("abort wr_data", int'(wr_data), 0);
    rst = 1'b0;
    step();
    check("abort post wr_en", int'(wr_en), 0);
    check("abort post busy", int'(busy), 0);

    // Reset overrides a simultaneous press.
    rst = 1'b1;
    set_btns(5'b01000);
    step();
    set_btns(5'b00000);
    rst = 1'b0;
    check("rst over press row", int'(cur_row), 0);

    // DIM=4 build: four downs from row 0 return to row 0.
    for (int i = 0; i < 4; i++) begin
      b4_down = 1'b1;
      step();
      b4_down = 1'b0;
      check($sformatf("dim4 down%0d row", i + 1), int'(d4_row), (i + 1) % 4);
      check($sformatf("dim4 down%0d rd_addr", i + 1), int'(d4_rd_addr), ((i + 1) % 4) * 4);
    end
    check("dim4 busy", int'(d4_busy), 0);
    check("dim4 wr_en", int'(d4_wr_en), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
